// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key schedule controller: expands one cipher key into NR+1 round
// keys, one KeyGeneration step per clock, and serves them on a registered
// random-access read port. The decryptor consumes them from round NR down to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no valid schedule; waiting for a cipher key
// EXPAND | generating rk[cnt+1] from rk[cnt] each clock
// READY  | all NR+1 round keys valid; a new key may still be accepted
module aes128_key_schedule_ctrl #(
  parameter int NR     = 10,
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_key_schedule_ctrl: only NR=10 is supported");
  end
  if (RD_REG != 1) begin : g_rd_reg_check
    $error("aes128_key_schedule_ctrl: only RD_REG=1 is supported");
  end

  localparam logic [3:0] LAST_RC = 4'(NR - 1);
  localparam logic [3:0] MAX_IDX = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           accept;
  logic [127:0]   rk_q [NR+1];
  logic [127:0]   kg_key;
  logic           rd_valid_q;
  logic [127:0]   rd_key_q;
  logic           rd_err_q;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as a^254 (multiplicative inverse, 0 maps to 0) followed
  // by the affine transform; avoids carrying a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] r;
    case (rc)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One AES-128 KeyGeneration round; w0 lives in bits [127:96]
  function automatic logic [127:0] key_gen(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon(rc), 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign kg_key     = key_gen(rk_q[cnt_q], cnt_q);
  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_ready = (state_q == READY);

  // State and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept a key outside EXPAND, step once per clock inside it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          accept  = 1'b1;
          state_d = EXPAND;
          cnt_d   = 4'd0;
        end
      end
      EXPAND: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_RC) begin
          state_d = READY;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Round-key storage; contents are only observable once READY, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      rk_q[0] <= key_in;
    end else if (busy) begin
      rk_q[cnt_q + 4'd1] <= kg_key;
    end
  end

  // Registered read port; uses pre-edge state so an overlapping rekey
  // still returns the old schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_en && keys_ready) begin
        rd_valid_q <= 1'b1;
        if (rd_round <= MAX_IDX) begin
          rd_key_q <= rk_q[rd_round];
          rd_err_q <= 1'b0;
        end else begin
          rd_key_q <= '0;
          rd_err_q <= 1'b1;
        end
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_key   = rd_key_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Bench for aes128_key_schedule_ctrl: a schedule-level reference model
// (whole key expansion computed at accept time from the AES definition)
// compared against the DUT on every falling edge, plus FIPS-197 literals.
module tb_aes128_key_schedule_ctrl;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         keys_ready;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  aes128_key_schedule_ctrl #(.NR(10), .RD_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .busy(busy), .keys_ready(keys_ready),
    .rd_en(rd_en), .rd_round(rd_round),
    .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
  );

  typedef logic [127:0] sched_t [11];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from the definition: brute-force inverse, then affine map
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] r;
    for (int y = 1; y < 256; y++)
      if (a != 8'h00 && gm(a, 8'(y)) == 8'h01) inv = 8'(y);
    r = 8'h63;
    for (int k = 0; k < 5; k++) r ^= 8'((inv << k) | (inv >> (8 - k)));
    return r;
  endfunction

  function automatic sched_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t s;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Reference model: schedule of the last accepted key, cycles since accept
  sched_t       m_sched;
  bit           m_have = 1'b0;
  int           m_age = 0;
  logic         m_vld = 1'b0;
  logic [127:0] m_key = '0;
  logic         m_err = 1'b0;
  bit           m_kr, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 1'b0; m_age = 0; m_vld = 1'b0; m_key = '0; m_err = 1'b0;
    end else begin
      m_kr  = m_have && m_age >= 10;
      m_acc = !(m_have && m_age < 10);
      if (rd_en && m_kr) begin
        m_vld = 1'b1;
        if (rd_round <= 4'd10) begin m_key = m_sched[rd_round]; m_err = 1'b0; end
        else begin m_key = '0; m_err = 1'b1; end
      end else begin
        m_vld = 1'b0;
      end
      if (m_have && m_age < 1000) m_age++;
      if (key_valid && m_acc) begin
        m_sched = expand(key_in);
        m_have  = 1'b1;
        m_age   = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    chk("key_ready", 128'(key_ready), 128'(!(m_have && m_age < 10)));
    chk("busy", 128'(busy), 128'(m_have && m_age < 10));
    chk("keys_ready", 128'(keys_ready), 128'(m_have && m_age >= 10));
    chk("rd_valid", 128'(rd_valid), 128'(m_vld));
    chk("rd_key", rd_key, m_key);
    chk("rd_err", 128'(rd_err), 128'(m_err));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_keys_ready"}, 128'(keys_ready), 128'(0));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    chk({tag, "_rd_key"}, rd_key, 128'(0));
    chk({tag, "_rd_err"}, 128'(rd_err), 128'(0));
  endtask

  task automatic rd_lit(input logic [3:0] r, input logic [127:0] exp_key, input logic exp_err);
    rd_en = 1'b1; rd_round = r;
    tick();
    rd_en = 1'b0;
    chk($sformatf("rd%0d_valid", r), 128'(rd_valid), 128'(1));
    chk($sformatf("rd%0d_key", r), rd_key, exp_key);
    chk($sformatf("rd%0d_err", r), 128'(rd_err), 128'(exp_err));
  endtask

  sched_t s1, s2;
  int n;

  initial begin
    s1 = expand(K1);
    s2 = expand(K2);
    chk("model_k1_r1", s1[1], K1_R1);
    chk("model_k1_r10", s1[10], K1_R10);
    chk("model_k2_r10", s2[10], K2_R10);

    #2 rst_n = 1'b0;
    #1 reset_lits("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // first key; a read and a foreign key are thrown at it mid-expansion
    key_in = K1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; key_in = '0;
    n = 0;
    while (busy && n < 20) begin
      rd_en = (n == 3); rd_round = 4'd0;
      key_valid = (n == 5); key_in = (n == 5) ? K2 : '0;
      n++;
      tick();
    end
    rd_en = 1'b0; key_valid = 1'b0; key_in = '0;
    chk("busy_cycles", 128'(n), 128'(10));
    chk("keys_ready_after_expand", 128'(keys_ready), 128'(1));

    rd_lit(4'd1, K1_R1, 1'b0);
    rd_lit(4'd10, K1_R10, 1'b0);
    rd_lit(4'd0, K1, 1'b0);
    rd_lit(4'd11, '0, 1'b1);
    rd_lit(4'd15, '0, 1'b1);

    // reverse burst, one request per cycle
    rd_en = 1'b1; rd_round = 4'd10;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("burst%0d_valid", 10 - i), 128'(rd_valid), 128'(1));
      chk($sformatf("burst%0d_key", 10 - i), rd_key, s1[10 - i]);
      if (i < 10) rd_round = 4'(9 - i);
      else rd_en = 1'b0;
    end
    tick();

    // rekey overlapping a read of round 0
    key_valid = 1'b1; key_in = K2; rd_en = 1'b1; rd_round = 4'd0;
    tick();
    key_valid = 1'b0; key_in = '0; rd_en = 1'b0;
    chk("overlap_old_key", rd_key, K1);
    chk("overlap_keys_ready_drop", 128'(keys_ready), 128'(0));
    n = 0;
    while (!keys_ready && n < 20) begin
      n++;
      tick();
    end
    chk("rekey_cycles", 128'(n), 128'(10));
    rd_lit(4'd10, K2_R10, 1'b0);

    // reset while cnt == 5
    key_valid = 1'b1; key_in = K1;
    tick();
    key_valid = 1'b0; key_in = '0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 reset_lits("midreset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (15) tick();
    chk("no_keys_ready_after_reset", 128'(keys_ready), 128'(0));

    key_valid = 1'b1; key_in = K2;
    tick();
    key_valid = 1'b0; key_in = '0;
    n = 0;
    while (!keys_ready && n < 20) begin
      n++;
      tick();
    end
    chk("post_reset_cycles", 128'(n), 128'(10));
    rd_lit(4'd10, K2_R10, 1'b0);
    rd_lit(4'd0, K2, 1'b0);
    rd_lit(4'd5, s2[5], 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes128_key_schedule_ctrl.md
Name: aes128_key_schedule_ctrl

Overview:
- Sequential key-expansion controller that feeds the AES-128 decryptor its round keys.
- Accepts a 128-bit cipher key over a valid/ready handshake and iterates one KeyGeneration instance (combinational, rc 0..9) once per clock.
- Stores all 11 round keys in an internal buffer and serves them on a random-access read port.
- The decryptor reads the keys in reverse order (round 10 down to 0).

Parameters:
- NR, 10: number of expansion rounds. Only 10 is supported, and elaboration shall fail otherwise. Storage holds NR+1 keys.
- RD_REG, 1: read-port latency in cycles. 1 means the output is registered. 0 is not supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key_in holds a new cipher key.
- key_ready  out  1  block can accept a key.
- key_in  in  128  cipher key; word w0 is in bits [127:96].
- busy  out  1  expansion in progress.
- keys_ready  out  1  all NR+1 round keys are valid in storage.
- rd_en  in  1  read request.
- rd_round  in  4  round key index to read, 0..NR.
- rd_valid  out  1  rd_key and rd_err are valid this cycle.
- rd_key  out  128  requested round key.
- rd_err  out  1  the request used rd_round > NR.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, round counter cnt=0.
  - key_ready=1, busy=0, keys_ready=0.
  - rd_valid=0, rd_key=0, rd_err=0.
  - Key storage contents are don't-care. They are unobservable because keys_ready=0.
- States: IDLE, EXPAND, READY.
  - key_ready = (state != EXPAND).
  - busy = (state == EXPAND).
  - keys_ready = (state == READY).
- Accept edge: a rising edge with key_valid && key_ready.
  - rk[0] <= key_in, cnt <= 0, state -> EXPAND.
  - This applies from IDLE or READY. Accepting in READY drops keys_ready on the same edge.
- EXPAND, each edge:
  - rk[cnt+1] <= KeyGeneration(rc=cnt, key=rk[cnt]); cnt <= cnt+1.
  - When cnt == NR-1, the edge writes rk[NR], then state -> READY and cnt <= 0.
  - rk[1] is written on the 1st edge after the accept edge; rk[10] is written on the 10th.
  - keys_ready is first high in the cycle after the 10th edge.
  - key_valid is ignored (key_ready=0), and key_in need not be held.
- READY: holds until the next accept edge or reset. Storage is stable.
- Read port (one request per cycle, no back-pressure):
  - When rd_en && keys_ready at edge E, then at E: rd_valid <= 1.
    - If rd_round <= NR: rd_key <= rk[rd_round], rd_err <= 0.
    - Else: rd_key <= 0, rd_err <= 1.
  - When rd_en && !keys_ready (IDLE or EXPAND): request dropped, rd_valid <= 0, rd_key and rd_err hold.
  - When rd_en=0: rd_valid <= 0, rd_key and rd_err hold their last values.
- Simultaneous read and key accept in READY: the read returns the pre-accept (old) key, including for rd_round=0.
- Reset mid-EXPAND: returns to IDLE immediately. A new key must be re-sent, and no partial keys_ready is ever reported.
- KeyGeneration rcon mapping: rc 0..9 gives 01,02,04,08,10,20,40,80,1b,36 in the top byte. cnt never exceeds 9 on the rc input.

Test Plan:
- FIPS-197 key: reset, send key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - key_ready=0 and busy=1 for exactly 10 cycles, then keys_ready=1.
  - rd_round=1 returns a0fafe1788542cb123a339392a6c7605 one cycle later with rd_valid=1.
  - rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=0 returns the original key.
- Reverse burst: with keys_ready, issue rd_en on 11 consecutive cycles with rd_round=10..0.
  - rd_valid is high for 11 consecutive cycles.
  - Keys match the FIPS-197 Appendix A.1 schedule in order, rd_err=0 throughout.
- Out of range and early read: rd_round=11 or 15 while ready gives rd_valid=1, rd_err=1, rd_key=0. rd_en during EXPAND gives rd_valid=0 and storage is unaffected.
- Rekey with overlapping read: in READY, assert key_valid with key_in=000102030405060708090a0b0c0d0e0f on the same edge as rd_en with rd_round=0.
  - rd_key=2b7e...4f3c (old key).
  - keys_ready drops, then rises 10 cycles later.
  - rd_round=10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- Key during expansion: pulse key_valid with a different key mid-EXPAND. It is ignored (key_ready=0), and the final keys match the first key.
- Reset mid-expansion: drop rst_n at cnt=5.
  - All outputs return to reset values asynchronously, state=IDLE, keys_ready stays 0 after release.
  - A new key then expands correctly.
